riscv_dbus_ctrl: RTL

RISCV_DBUS_CTRL -- requirements
Module: riscv_dbus_ctrl

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/riscv_load_ext.sv | 38 +++
 rtl/riscv_dbus_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the data-bus controller: funct3 encodings,
// controller states and the lane/byte-enable helpers.
package riscv_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_func_e;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_REQ,
        DB_RESP,
        DB_DONE
    } dbus_state_e;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b1;
            2'b01:   return (lo[0] == 1'b0);
            default: return (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// Combinational load-data extraction: picks the byte/half lane by address
// and sign- or zero-extends according to funct3.
module riscv_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = '0;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext = rdata;
        case (func)
            MEM_B:   ext = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  ext = {24'h0, byte_sel};
            MEM_H:   ext = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  ext = {16'h0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_dbus_ctrl.sv
// M-stage data-bus controller: accepts one aligned load/store, runs a
// req/gnt then rvalid handshake with timeout, and pulses done for a cycle.
module riscv_dbus_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_reqM,
    input  logic        i_mem_weM,
    input  logic [2:0]  i_mem_funcM,
    input  logic [31:0] i_mem_addrM,
    input  logic [31:0] i_mem_wdataM,
    input  logic        i_flushM,
    output logic        o_bus_stallM,
    output logic [31:0] o_rdataM,
    output logic        o_doneM,
    output logic        o_misalignM,
    output logic        o_bus_errM,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    dbus_state_e state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  func_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] ext_data;

    logic access_ok, accept, misalign_hit, in_bus, timeout;

    riscv_load_ext u_load_ext (
        .rdata   (i_bus_rdata),
        .addr_lo (addr_q[1:0]),
        .func    (func_q),
        .ext     (ext_data)
    );

    always_comb begin
        access_ok    = is_aligned(i_mem_funcM[1:0], i_mem_addrM[1:0]);
        accept       = (state == DB_IDLE) && i_mem_reqM && !i_flushM && access_ok;
        misalign_hit = (state == DB_IDLE) && i_mem_reqM && !i_flushM && !access_ok;
        in_bus       = (state == DB_REQ) || (state == DB_RESP);
        timeout      = in_bus && (cnt == TO_LIM);
    end

    // timeout outranks gnt/rvalid so the REQ+RESP window never exceeds the limit
    always_comb begin
        state_nxt = state;
        case (state)
            DB_IDLE: if (accept) state_nxt = DB_REQ;
            DB_REQ:  if (timeout) state_nxt = DB_DONE;
                     else if (i_bus_gnt) state_nxt = DB_RESP;
            DB_RESP: if (timeout || i_bus_rvalid) state_nxt = DB_DONE;
            DB_DONE: state_nxt = DB_IDLE;
            default: state_nxt = DB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DB_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            func_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                DB_IDLE: begin
                    err_q <= 1'b0;
                    if (accept) begin
                        cnt     <= '0;
                        addr_q  <= i_mem_addrM;
                        wdata_q <= i_mem_wdataM;
                        func_q  <= i_mem_funcM;
                        we_q    <= i_mem_weM;
                    end
                end
                DB_REQ, DB_RESP: begin
                    cnt   <= cnt + 8'd1;
                    err_q <= timeout;
                    if (timeout) begin
                        rdata_q <= '0;
                    end else if ((state == DB_RESP) && i_bus_rvalid) begin
                        rdata_q <= we_q ? '0 : ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_bus_stallM = accept || in_bus;
        o_misalignM  = misalign_hit;
        o_doneM      = (state == DB_DONE);
        o_bus_errM   = (state == DB_DONE) && err_q;
        o_rdataM     = rdata_q;
        o_bus_req    = (state == DB_REQ);
        o_bus_we     = '0;
        o_bus_addr   = '0;
        o_bus_wdata  = '0;
        o_bus_be     = '0;
        if (state == DB_REQ) begin
            o_bus_we    = we_q;
            o_bus_addr  = {addr_q[31:2], 2'b00};
            o_bus_wdata = wdata_gen(func_q[1:0], wdata_q);
            o_bus_be    = be_gen(func_q[1:0], addr_q[1:0]);
        end
    end

endmodule
